// File: rtl/divider_pkg.sv
// Shared types for the RV32M divider: operation encoding, FSM states and
// small decode helpers used by the datapath.
package divider_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } DivOp;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } DivState;

    function automatic logic is_signed_op(input DivOp op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input DivOp op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/Adder.sv
// Team adder: WIDTH-bit sum with carry-in and carry-out; used by the divider
// for trial subtraction (a + ~b + 1) and two's-complement negation.
module Adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_carry};

endmodule

// File: rtl/int_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
module int_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operandA,
    input  logic [WIDTH-1:0] i_operandB,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);
    import divider_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    DivState          state, state_next;
    DivOp             op;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] div_mag, rem, quo;
    logic [CNT_W-1:0] cnt;

    // Request decode, evaluated every cycle but only consumed on accept.
    DivOp             in_op;
    logic             in_signed, in_rem, a_neg, b_neg, div_zero, overflow;
    logic [WIDTH-1:0] mag_a, mag_b, special_result;

    always_comb begin
        in_op     = DivOp'(i_op);
        in_signed = is_signed_op(in_op);
        in_rem    = is_rem_op(in_op);
        a_neg     = in_signed & i_operandA[WIDTH-1];
        b_neg     = in_signed & i_operandB[WIDTH-1];
        mag_a     = a_neg ? (~i_operandA + WIDTH'(1)) : i_operandA;
        mag_b     = b_neg ? (~i_operandB + WIDTH'(1)) : i_operandB;
        div_zero  = (i_operandB == '0);
        overflow  = in_signed && (i_operandA == MIN_INT) && (i_operandB == '1);
        if (div_zero)
            special_result = in_rem ? i_operandA : '1;
        else
            special_result = in_rem ? '0 : i_operandA;
    end

    // Partial remainder shifted one place left; its bit WIDTH is rem[WIDTH-1],
    // which the WIDTH-bit adder cannot see, so it is ORed into the no-borrow test.
    logic [WIDTH-1:0] rem_sh, trial;
    logic             trial_carry, no_borrow;

    assign rem_sh    = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign no_borrow = rem[WIDTH-1] | trial_carry;

    Adder #(.WIDTH(WIDTH)) u_trial (
        .i_a     (rem_sh),
        .i_b     (~div_mag),
        .i_carry (1'b1),
        .o_sum   (trial),
        .o_carry (trial_carry)
    );

    // Sign fixup: only the selected result is ever negated, so one adder suffices.
    logic [WIDTH-1:0] fix_sel, neg_sum, fix_result;
    logic             fix_neg, neg_zero;

    assign fix_sel = is_rem_op(op) ? rem : quo;
    assign fix_neg = is_rem_op(op) ? sign_a : (sign_a ^ sign_b);

    Adder #(.WIDTH(WIDTH)) u_negate (
        .i_a     (~fix_sel),
        .i_b     ({WIDTH{1'b0}}),
        .i_carry (1'b1),
        .o_sum   (neg_sum),
        .o_carry (neg_zero)
    );

    // Carry out means fix_sel was zero, whose negation is itself.
    assign fix_result = (fix_neg && !neg_zero) ? neg_sum : fix_sel;

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (i_start) state_next = (div_zero || overflow) ? DONE : CALC;
            CALC:    if (cnt == '0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_busy = (state == CALC) || (state == FIXUP);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= (state == DONE);
            if (state == IDLE && i_start && (div_zero || overflow))
                o_result <= special_result;
            else if (state == FIXUP)
                o_result <= fix_result;
        end
    end

    // NOTE: working registers carry no reset; the FSM never reads them before an accept loads them.
    always_ff @(posedge i_clock) begin
        case (state)
            IDLE: if (i_start) begin
                op      <= in_op;
                sign_a  <= a_neg;
                sign_b  <= b_neg;
                div_mag <= mag_b;
                rem     <= '0;
                quo     <= mag_a;
                cnt     <= CNT_W'(WIDTH - 1);
            end
            CALC: begin
                rem <= no_borrow ? trial : rem_sh;
                quo <= {quo[WIDTH-2:0], no_borrow};
                cnt <= cnt - CNT_W'(1);
            end
            default: ;
        endcase
    end

endmodule
